rtype_instruction_encoder: RTL

- Inverse of the R-type decoder. Accepts ALU operation requests as {opALU code, rd, rs1, rs2} and encodes each into a 32-bit RISC-V R-type word.
- Buffers encoded words in a small FIFO and presents them to the processor/instruction-memory loader over a valid/ready handshake.
- Acts as the instruction source for self-checking decoder/ALU benches and for FPGA bring-up loaders.

---
 rtl/rtype_instruction_encoder_pkg.sv | 72 +++++++
 rtl/rtype_instruction_encoder_instr_fifo.sv | 52 +++++
 rtl/rtype_instruction_encoder.sv | 90 +++++++++
 3 files changed

// File: rtl/rtype_instruction_encoder_pkg.sv
// Shared R-type constants (opcode, opALU codes, fun7/fun3, field positions) and the
// encode helper used by both the encoder and the decoder.
package rtype_instruction_encoder_pkg;

  localparam logic [6:0] OPCODERT = 7'b0110011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [6:0] FUN7_BASE = 7'b0000000;
  localparam logic [6:0] FUN7_ALT  = 7'b0100000;

  localparam logic [2:0] FUN3_ADDSUB = 3'b000;
  localparam logic [2:0] FUN3_SLL    = 3'b001;
  localparam logic [2:0] FUN3_SLT    = 3'b010;
  localparam logic [2:0] FUN3_SLTU   = 3'b011;
  localparam logic [2:0] FUN3_XOR    = 3'b100;
  localparam logic [2:0] FUN3_SR     = 3'b101;
  localparam logic [2:0] FUN3_OR     = 3'b110;
  localparam logic [2:0] FUN3_AND    = 3'b111;

  localparam int OPC_LSB  = 0;
  localparam int RD_LSB   = 7;
  localparam int FUN3_LSB = 12;
  localparam int RS1_LSB  = 15;
  localparam int RS2_LSB  = 20;
  localparam int FUN7_LSB = 25;

  function automatic logic is_legal_op(input logic [3:0] op);
    return op <= ALU_SRA;
  endfunction

  // Illegal codes produce an ADD-shaped word; the caller never stores it.
  function automatic logic [31:0] encode_rtype(input logic [3:0] op, input logic [4:0] rd,
                                               input logic [4:0] rs1, input logic [4:0] rs2);
    logic [6:0]  fun7;
    logic [2:0]  fun3;
    logic [31:0] word;
    fun7 = FUN7_BASE;
    fun3 = FUN3_ADDSUB;
    case (op)
      ALU_ADD:  fun3 = FUN3_ADDSUB;
      ALU_SUB:  begin fun7 = FUN7_ALT; fun3 = FUN3_ADDSUB; end
      ALU_AND:  fun3 = FUN3_AND;
      ALU_OR:   fun3 = FUN3_OR;
      ALU_XOR:  fun3 = FUN3_XOR;
      ALU_SLT:  fun3 = FUN3_SLT;
      ALU_SLTU: fun3 = FUN3_SLTU;
      ALU_SLL:  fun3 = FUN3_SLL;
      ALU_SRL:  fun3 = FUN3_SR;
      ALU_SRA:  begin fun7 = FUN7_ALT; fun3 = FUN3_SR; end
      default:  fun3 = FUN3_ADDSUB;
    endcase
    word = '0;
    word[OPC_LSB  +: 7] = OPCODERT;
    word[RD_LSB   +: 5] = rd;
    word[FUN3_LSB +: 3] = fun3;
    word[RS1_LSB  +: 5] = rs1;
    word[RS2_LSB  +: 5] = rs2;
    word[FUN7_LSB +: 7] = fun7;
    return word;
  endfunction

endpackage

// File: rtl/rtype_instruction_encoder_instr_fifo.sv
// instr_fifo: DEPTH x WIDTH synchronous FIFO with full/empty/level, async active-high reset.
// Pointers carry one extra MSB so that full and empty are distinguishable.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};

  // Head is read asynchronously so a word written this cycle is presented next cycle.
  assign data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/rtype_instruction_encoder.sv
// Encodes {opALU, rd, rs1, rs2} requests into RISC-V R-type words and queues them for a
// valid/ready consumer. Define ENCODER_STATS_EN to build the issued/illegal counters.
module rtype_instruction_encoder
  import rtype_instruction_encoder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNTW  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    reqValid,
  output logic                    reqReady,
  input  logic [3:0]              reqOp,
  input  logic [4:0]              reqRd,
  input  logic [4:0]              reqRs1,
  input  logic [4:0]              reqRs2,
  output logic                    instrValid,
  input  logic                    instrReady,
  output logic [31:0]             instruction,
  output logic                    errIllegal,
  output logic [$clog2(DEPTH):0]  fillLevel,
  output logic [CNTW-1:0]         issuedCount,
  output logic [CNTW-1:0]         illegalCount
);

  localparam int AW = $clog2(DEPTH);

  logic          fifo_full, fifo_empty;
  logic [AW:0]   fifo_level;
  logic [31:0]   fifo_head, enc_word;
  logic          accept, op_legal, push, pop, illegal_accept;
  logic          err_illegal_q;

  assign enc_word = encode_rtype(reqOp, reqRd, reqRs1, reqRs2);
  assign op_legal = is_legal_op(reqOp);

  // reqReady depends only on registered pointers, never on instrReady.
  assign reqReady       = !fifo_full;
  assign accept         = reqValid && reqReady;
  assign push           = accept && op_legal;
  assign illegal_accept = accept && !op_legal;
  assign pop            = !fifo_empty && instrReady;

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_instr_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (push),
    .data_i  (enc_word),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign instrValid  = !fifo_empty;
  assign instruction = fifo_empty ? 32'h0 : fifo_head;
  assign fillLevel   = fifo_level;
  assign errIllegal  = err_illegal_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_illegal_q <= 1'b0;
    else       err_illegal_q <= illegal_accept;
  end

`ifdef ENCODER_STATS_EN
  logic [CNTW-1:0] issued_q, illegal_cnt_q;

  // Both counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issued_q      <= '0;
      illegal_cnt_q <= '0;
    end else begin
      if (pop && issued_q != '1)                 issued_q      <= issued_q + 1'b1;
      if (illegal_accept && illegal_cnt_q != '1) illegal_cnt_q <= illegal_cnt_q + 1'b1;
    end
  end

  assign issuedCount  = issued_q;
  assign illegalCount = illegal_cnt_q;
`else
  assign issuedCount  = '0;
  assign illegalCount = '0;
`endif

endmodule
